// File: rtl/rd_req_arbiter.sv
// rd_req_arbiter: shares one AXI read-address/read-data channel pair between instruction
// fetch (ARID 0) and data load (ARID 1); one AR in flight, R beats steered back by RID.
module rd_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [2:0]        inst_size,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [2:0]        data_size,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic              rid_err
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE,
        S_AR_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [2:0]        r_arsize;
    logic              r_pend_i;
    logic              r_pend_d;
    logic              r_rid_err;
    logic [CNT_W-1:0]  r_starve_cnt;

    logic w_elig_i;
    logic w_elig_d;
    logic w_grant_i;
    logic w_grant_d;
    logic w_ar_fire;
    logic w_hit_i;
    logic w_hit_d;
    logic w_r_bad;

    // Eligibility deliberately uses the registered pend bits, so a completion this cycle
    // only re-enables its requester next cycle.
    assign w_elig_i  = inst_req & ~r_pend_i;
    assign w_elig_d  = data_req & ~r_pend_d;
    assign w_ar_fire = (r_state == S_AR_WAIT) & arready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_elig_d && !(w_elig_i && (r_starve_cnt == CNT_MAX))) begin
                    w_grant_d = 1'b1;
                end else if (w_elig_i) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = S_AR_WAIT;
                end
            end
            S_AR_WAIT: begin
                if (arready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_arid   <= 4'd0;
            r_araddr <= '0;
            r_arsize <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_d) begin
                r_arid   <= 4'd1;
                r_araddr <= data_addr;
                r_arsize <= data_size;
            end else if (w_grant_i) begin
                r_arid   <= 4'd0;
                r_araddr <= inst_addr;
                r_arsize <= inst_size;
            end
        end
    end

    assign w_hit_i = rvalid & (rid == 4'd0) & r_pend_i;
    assign w_hit_d = rvalid & (rid == 4'd1) & r_pend_d;
    assign w_r_bad = rvalid & ~w_hit_i & ~w_hit_d;

    // An AR handshake and an R beat for the other id may land in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_i  <= 1'b0;
            r_pend_d  <= 1'b0;
            r_rid_err <= 1'b0;
        end else begin
            r_pend_i  <= (r_pend_i & ~w_hit_i) | (w_ar_fire & (r_arid == 4'd0));
            r_pend_d  <= (r_pend_d & ~w_hit_d) | (w_ar_fire & (r_arid == 4'd1));
            r_rid_err <= r_rid_err | w_r_bad;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (!inst_req || w_grant_i) begin
            r_starve_cnt <= '0;
        end else if (w_elig_i && w_grant_d && (r_starve_cnt != CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign inst_addr_ok = rst & w_grant_i;
    assign data_addr_ok = rst & w_grant_d;
    assign inst_data_ok = rst & w_hit_i;
    assign data_data_ok = rst & w_hit_d;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign rready       = rst;
    assign rid_err      = r_rid_err;

    assign arvalid = (r_state == S_AR_WAIT);
    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arsize  = r_arsize;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// tb_rd_req_arbiter: directed plus randomized traffic against a transaction-level model;
// expected AR and R results are queued at issue time and retired by a separate monitor.
module tb_rd_req_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, inst_addr_ok, data_addr_ok;
    logic        inst_data_ok, data_data_ok;
    logic [31:0] inst_addr, data_addr, inst_rdata, data_rdata;
    logic [2:0]  inst_size, data_size, arsize;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic        arvalid, arready, rvalid, rready, rid_err;

    always #5 clk = ~clk;

    rd_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .rid_err(rid_err)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_t;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
    } r_t;

    int  nChecks = 0;
    int  nFails  = 0;
    ar_t arQ[$];
    r_t  rQ[$];

    bit       mBusy;
    ar_t      mAr;
    bit [1:0] mPend;
    int       mStarve;
    bit       mErr;
    bit       mGrantI, mGrantD;
    bit       dutGrantI, dutGrantD;

    logic        sIReq, sDReq, sArRdy, sRV;
    logic [31:0] sIAddr, sDAddr, sRData;
    logic [2:0]  sISize, sDSize;
    logic [3:0]  sRId;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mBusy = 0; mAr = '0; mPend = 2'b00; mStarve = 0; mErr = 0;
        arQ.delete(); rQ.delete();
        sIReq = 0; sDReq = 0; sArRdy = 0; sRV = 0; sRId = 4'd0; sRData = '0;
        sIAddr = '0; sDAddr = '0; sISize = 3'd0; sDSize = 3'd0;
    endtask

    // One clock of stimulus: drive, predict from the arbitration rules, check mid-cycle, advance model.
    task automatic applyStimulus();
        bit  eligI, eligD, hit;
        ar_t a;
        r_t  r;
        @(posedge clk); #1;
        inst_req = sIReq; inst_addr = sIAddr; inst_size = sISize;
        data_req = sDReq; data_addr = sDAddr; data_size = sDSize;
        arready = sArRdy; rvalid = sRV; rid = sRId; rdata = sRData;
        eligI   = sIReq && !mPend[0];
        eligD   = sDReq && !mPend[1];
        mGrantD = !mBusy && eligD && !(eligI && mStarve == LIMIT);
        mGrantI = !mBusy && eligI && !mGrantD;
        hit     = sRV && (sRId < 4'd2) && mPend[sRId[0]];
        if (sRV) begin
            r.port = hit ? {1'b0, sRId[0]} : 2'd2;
            r.data = sRData;
            rQ.push_back(r);
        end
        if (mGrantI) begin a.id = 4'd0; a.addr = sIAddr; a.size = sISize; arQ.push_back(a); end
        if (mGrantD) begin a.id = 4'd1; a.addr = sDAddr; a.size = sDSize; arQ.push_back(a); end
        @(negedge clk);
        checkOutput("inst_addr_ok", 64'(inst_addr_ok), 64'(mGrantI));
        checkOutput("data_addr_ok", 64'(data_addr_ok), 64'(mGrantD));
        checkOutput("arvalid", 64'(arvalid), 64'(mBusy));
        if (mBusy) begin
            checkOutput("arid", 64'(arid), 64'(mAr.id));
            checkOutput("araddr", 64'(araddr), 64'(mAr.addr));
            checkOutput("arsize", 64'(arsize), 64'(mAr.size));
        end
        checkOutput("rready", 64'(rready), 64'd1);
        checkOutput("rid_err", 64'(rid_err), 64'(mErr));
        checkOutput("inst_rdata_pass", 64'(inst_rdata), 64'(sRData));
        checkOutput("data_rdata_pass", 64'(data_rdata), 64'(sRData));
        dutGrantI = inst_addr_ok;
        dutGrantD = data_addr_ok;
        if (hit) mPend[sRId[0]] = 1'b0;
        if (sRV && !hit) mErr = 1'b1;
        if (mBusy && sArRdy) begin mPend[mAr.id[0]] = 1'b1; mBusy = 0; end
        if (mGrantI || mGrantD) begin mBusy = 1; mAr = a; end
        if (!sIReq || mGrantI) mStarve = 0;
        else if (eligI && mGrantD && mStarve < LIMIT) mStarve++;
    endtask

    // Retire queued expectations whenever the DUT completes an AR or R handshake.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (arvalid && arready) begin
                if (arQ.size() == 0) begin
                    nChecks++; nFails++;
                    $display("[TB] FAIL ar_unexpected: got arid %0h araddr %0h, expected no AR", arid, araddr);
                end else begin
                    ar_t e;
                    e = arQ.pop_front();
                    checkOutput("sb_arid", 64'(arid), 64'(e.id));
                    checkOutput("sb_araddr", 64'(araddr), 64'(e.addr));
                    checkOutput("sb_arsize", 64'(arsize), 64'(e.size));
                end
            end
            if (rvalid && rready) begin
                if (rQ.size() == 0) begin
                    nChecks++; nFails++;
                    $display("[TB] FAIL r_unexpected: got R beat rid %0h, expected none", rid);
                end else begin
                    r_t e;
                    e = rQ.pop_front();
                    checkOutput("sb_inst_data_ok", 64'(inst_data_ok), 64'(e.port == 2'd0));
                    checkOutput("sb_data_data_ok", 64'(data_data_ok), 64'(e.port == 2'd1));
                    if (e.port == 2'd0) checkOutput("sb_inst_rdata", 64'(inst_rdata), 64'(e.data));
                    if (e.port == 2'd1) checkOutput("sb_data_rdata", 64'(data_rdata), 64'(e.data));
                end
            end
        end
    end

    task automatic dropGranted();
        if (dutGrantI) sIReq = 0;
        if (dutGrantD) sDReq = 0;
    endtask

    initial begin
        int dWins;
        bit gotInst;
        resetModel();
        rst = 1'b0;
        inst_req = 1; inst_addr = 32'h1234; inst_size = 3'd2;
        data_req = 1; data_addr = 32'h5678; data_size = 3'd2;
        arready = 1; rvalid = 1; rid = 4'd0; rdata = 32'h1;
        #12;
        checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
        checkOutput("rst_arid", 64'(arid), 64'd0);
        checkOutput("rst_araddr", 64'(araddr), 64'd0);
        checkOutput("rst_arsize", 64'(arsize), 64'd0);
        checkOutput("rst_rready", 64'(rready), 64'd0);
        checkOutput("rst_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
        checkOutput("rst_data_addr_ok", 64'(data_addr_ok), 64'd0);
        checkOutput("rst_inst_data_ok", 64'(inst_data_ok), 64'd0);
        checkOutput("rst_rid_err", 64'(rid_err), 64'd0);
        inst_req = 0; data_req = 0; rvalid = 0; arready = 0;
        #10 rst = 1'b1;

        $display("[TB] basic fetch");
        sIReq = 1; sIAddr = 32'h1c000000; sISize = 3'd2; sArRdy = 1;
        applyStimulus(); dropGranted();
        applyStimulus();
        sRV = 1; sRId = 4'd0; sRData = 32'hdeadbeef;
        applyStimulus();
        sRV = 0;

        $display("[TB] simultaneous requests, reverse-order replies");
        sIReq = 1; sIAddr = 32'h1c000010; sDReq = 1; sDAddr = 32'h80001000; sDSize = 3'd1;
        for (int c = 0; c < 4; c++) begin applyStimulus(); dropGranted(); end
        sRV = 1; sRId = 4'd0; sRData = 32'h11112222; applyStimulus();
        sRId = 4'd1; sRData = 32'h33334444; applyStimulus();
        sRV = 0;

        $display("[TB] starvation bound");
        sIReq = 1; sIAddr = 32'h1c000020; sDReq = 1; sDAddr = 32'h80002000;
        dWins = 0; gotInst = 0;
        for (int c = 0; c < 30 && !gotInst; c++) begin
            sRV = mPend[1]; sRId = 4'd1; sRData = $urandom;
            applyStimulus();
            if (dutGrantD) begin dWins++; sDAddr = sDAddr + 32'd4; end
            if (dutGrantI) begin gotInst = 1; sIReq = 0; end
        end
        checkOutput("starve_inst_granted", 64'(gotInst), 64'd1);
        checkOutput("starve_within_limit", 64'(dWins <= LIMIT), 64'd1);
        sDReq = 0;
        for (int c = 0; c < 4; c++) begin
            sRV = mPend[0] | mPend[1]; sRId = mPend[0] ? 4'd0 : 4'd1; sRData = $urandom;
            applyStimulus(); dropGranted();
        end
        sRV = 0;

        $display("[TB] arready held low");
        sIReq = 1; sIAddr = 32'h1c000040; sArRdy = 0;
        applyStimulus(); dropGranted();
        sDReq = 1; sDAddr = 32'h80003000;
        for (int c = 0; c < 5; c++) applyStimulus();
        sArRdy = 1;
        for (int c = 0; c < 3; c++) begin applyStimulus(); dropGranted(); end

        $display("[TB] unmatched R beat");
        sRV = 1; sRId = 4'd1; sRData = 32'h55;
        applyStimulus();
        sRId = 4'd0; sRData = 32'h66;
        applyStimulus();
        sRV = 1; sRId = 4'd0; sRData = 32'h77;
        applyStimulus();
        sRV = 0;
        for (int c = 0; c < 3; c++) applyStimulus();

        $display("[TB] reset during AR_WAIT");
        sIReq = 1; sIAddr = 32'h1c000080; sArRdy = 1;
        applyStimulus(); dropGranted(); applyStimulus();
        sDReq = 1; sDAddr = 32'h80004000; sArRdy = 0;
        applyStimulus(); dropGranted(); applyStimulus();
        @(posedge clk); #2 rst = 1'b0; #1;
        checkOutput("async_rst_arvalid", 64'(arvalid), 64'd0);
        checkOutput("async_rst_araddr", 64'(araddr), 64'd0);
        checkOutput("async_rst_rready", 64'(rready), 64'd0);
        @(negedge clk); #2;
        resetModel();
        inst_req = 0; data_req = 0; rvalid = 0; arready = 0;
        rst = 1'b1;
        sIReq = 1; sIAddr = 32'h1c0000c0; sISize = 3'd2; sArRdy = 1;
        applyStimulus(); dropGranted(); applyStimulus();

        $display("[TB] random traffic");
        for (int c = 0; c < 2000; c++) begin
            int pick;
            if (!sIReq && $urandom_range(0, 2) == 0) begin
                sIReq = 1; sIAddr = $urandom & 32'hFFFF_FFFC; sISize = 3'($urandom_range(0, 2));
            end
            if (!sDReq && $urandom_range(0, 2) == 0) begin
                sDReq = 1; sDAddr = $urandom & 32'hFFFF_FFFC; sDSize = 3'($urandom_range(0, 2));
            end
            sArRdy = ($urandom_range(0, 3) != 0);
            sRData = $urandom;
            sRV = 0; sRId = 4'd0;
            pick = $urandom_range(0, 39);
            if (pick == 0) begin
                sRV = 1; sRId = 4'($urandom_range(0, 15));
            end else if (pick < 18 && (mPend != 2'b00)) begin
                sRV = 1;
                if (mPend == 2'b11) sRId = 4'($urandom_range(0, 1));
                else sRId = mPend[0] ? 4'd0 : 4'd1;
            end
            applyStimulus(); dropGranted();
        end

        sRV = 0; sArRdy = 1;
        for (int c = 0; c < 12; c++) begin
            sRV = (mPend != 2'b00); sRId = mPend[0] ? 4'd0 : 4'd1; sRData = $urandom;
            applyStimulus(); dropGranted();
        end
        checkOutput("arq_drained", 64'(arQ.size()), 64'd0);
        checkOutput("rq_drained", 64'(rQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
